md_exec_unit: RTL and testbench

Multi-cycle signed multiply/divide unit that sits in the execute stage, directly downstream of the DX pipeline latch and alongside the ALU. It accepts a one-cycle start pulse with two 32-bit operands and a destination-register tag. It iterates for a fixed number of cycles and returns the result, an exception flag and the tag with a one-cycle ready pulse. The pipeline uses `busy` to stall FD/DX while an operation is in flight.

---
 rtl/md_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_md_exec_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/md_exec_unit.sv
// Multi-cycle signed multiply/divide unit for the execute stage.
// Radix-2 Booth multiply and restoring divide, one step per clock.
module md_exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  in_tag,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [4:0]  out_tag,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [5:0]  cnt;
    logic [4:0]  tag;

    logic [31:0] mcand;
    logic [32:0] acc;
    logic [31:0] mq;
    logic        q1;

    logic [31:0] dsor;
    logic [32:0] rem;
    logic [31:0] quo;
    logic        neg;

    logic        accept;
    logic        last;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] booth_sum;
    logic [63:0] prod;
    logic        mul_ovf;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] quo_n;
    logic [31:0] div_res;
    logic        div_ovf;

    always_comb begin
        accept   = ((state == IDLE) || (state == DONE)) &&
                   (ctrl_MULT || ctrl_DIV);
        last     = (cnt == 6'd31);
        div_zero = (data_operandB == 32'd0);
        mag_a    = data_operandA[31] ? -data_operandA : data_operandA;
        mag_b    = data_operandB[31] ? -data_operandB : data_operandB;

        // Accumulator is one bit wider so subtracting -2^31 cannot wrap.
        booth_sum = acc;
        unique case ({mq[0], q1})
            2'b01:   booth_sum = acc + {mcand[31], mcand};
            2'b10:   booth_sum = acc - {mcand[31], mcand};
            default: booth_sum = acc;
        endcase
        prod    = {booth_sum, mq[31:1]};
        mul_ovf = !((&prod[63:31]) || (~|prod[63:31]));

        shifted = {rem[31:0], quo[31]};
        diff    = {1'b0, shifted} - {2'b00, dsor};
        quo_n   = {quo[30:0], ~diff[33]};
        div_res = neg ? -quo_n : quo_n;
        // Only |quotient| == 2^31 with same signs exceeds signed range.
        div_ovf = !neg && quo_n[31];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (ctrl_MULT) begin
                    state_n = MUL;
                end else if (ctrl_DIV) begin
                    state_n = div_zero ? DONE : DIV;
                end else begin
                    state_n = IDLE;
                end
            end
            MUL: if (last) state_n = DONE;
            DIV: if (last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            tag            <= '0;
            mcand          <= '0;
            acc            <= '0;
            mq             <= '0;
            q1             <= 1'b0;
            dsor           <= '0;
            rem            <= '0;
            quo            <= '0;
            neg            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            out_tag        <= '0;
        end else if (accept) begin
            tag <= in_tag;
            cnt <= '0;
            if (ctrl_MULT) begin
                mcand <= data_operandA;
                acc   <= '0;
                mq    <= data_operandB;
                q1    <= 1'b0;
            end else begin
                dsor <= mag_b;
                rem  <= '0;
                quo  <= mag_a;
                neg  <= data_operandA[31] ^ data_operandB[31];
                if (div_zero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                    out_tag        <= in_tag;
                end
            end
        end else if (state == MUL) begin
            acc <= {booth_sum[32], booth_sum[32:1]};
            mq  <= {booth_sum[0], mq[31:1]};
            q1  <= mq[0];
            cnt <= cnt + 6'd1;
            if (last) begin
                data_result    <= prod[31:0];
                data_exception <= mul_ovf;
                out_tag        <= tag;
            end
        end else if (state == DIV) begin
            rem <= diff[33] ? shifted : diff[32:0];
            quo <= quo_n;
            cnt <= cnt + 6'd1;
            if (last) begin
                data_result    <= div_res;
                data_exception <= div_ovf;
                out_tag        <= tag;
            end
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == MUL) || (state == DIV);

endmodule

// File: tb/tb_md_exec_unit.sv
// Scoreboard bench for md_exec_unit: directed vectors, queue-based
// monitor checking result, exception, tag and ready cycle.
module tb_md_exec_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  in_tag;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [4:0]  out_tag;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    md_exec_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .in_tag         (in_tag),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .out_tag        (out_tag),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the head of the queue.
    always @(negedge clock) begin
        if (reset && data_resultRDY) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy: got rdy at cycle %0d expected none",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
                chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
                chk("rdy_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t,
                            input logic [31:0] res, input bit exc,
                            input int lat, input bit push);
        exp_t e;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        in_tag        = t;
        if (push) begin
            e.res = res;
            e.exc = exc;
            e.tag = t;
            e.cyc = cyc + 1 + lat;
            q.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        in_tag        = 5'($urandom);
    endtask

    task automatic wait_drain(input int bound);
        int i;
        for (i = 0; i < bound && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    int bcnt;

    initial begin
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        in_tag        = '0;
        repeat (3) @(negedge clock);
        chk("rst_result", data_result, 32'd0);
        chk("rst_flags", {28'd0, data_exception, data_resultRDY, busy, 1'b0},
            32'd0);
        chk("rst_tag", {27'd0, out_tag}, 32'd0);
        reset = 1'b1;

        // 7 * -3, first start on the first edge after release
        start_op(1, 0, 32'd7, -32'sd3, 5'd5, 32'hFFFFFFEB, 0, 32, 1);
        bcnt = 0;
        repeat (40) begin
            if (busy) bcnt++;
            @(negedge clock);
        end
        chk("mul_busy_cycles", bcnt, 32'd32);
        wait_drain(100);

        start_op(1, 0, 32'h00010000, 32'h00010000, 5'd1, 32'h0, 1, 32, 1);
        wait_drain(100);
        start_op(1, 0, 32'h7FFFFFFF, 32'd1, 5'd2, 32'h7FFFFFFF, 0, 32, 1);
        wait_drain(100);
        start_op(1, 0, 32'h80000000, 32'd1, 5'd3, 32'h80000000, 0, 32, 1);
        wait_drain(100);
        start_op(1, 0, 32'h80000000, 32'h80000000, 5'd4, 32'h0, 1, 32, 1);
        wait_drain(100);
        start_op(1, 1, 32'd6, 32'd7, 5'd6, 32'd42, 0, 32, 1);
        wait_drain(100);

        start_op(0, 1, -32'sd7, 32'd2, 5'd7, 32'hFFFFFFFD, 0, 32, 1);
        wait_drain(100);
        start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1, 32, 1);
        wait_drain(100);
        start_op(0, 1, -32'sd100, 32'd7, 5'd10, 32'hFFFFFFF2, 0, 32, 1);
        wait_drain(100);
        start_op(0, 1, 32'd100, -32'sd7, 5'd11, 32'hFFFFFFF2, 0, 32, 1);
        wait_drain(100);

        // divide by zero: straight to DONE, never busy
        start_op(0, 1, 32'd100, 32'd0, 5'd12, 32'h0, 1, 0, 1);
        bcnt = 0;
        repeat (4) begin
            if (busy) bcnt++;
            @(negedge clock);
        end
        chk("div0_busy_cycles", bcnt, 32'd0);
        wait_drain(10);

        // DIV start during MUL is ignored
        start_op(1, 0, -32'sd5, -32'sd6, 5'd13, 32'd30, 0, 32, 1);
        repeat (9) @(negedge clock);
        start_op(0, 1, 32'd50, 32'd5, 5'd14, 32'd0, 0, 0, 0);
        wait_drain(100);

        // back-to-back issue in the DONE cycle
        start_op(1, 0, 32'd1000, 32'd1000, 5'd15, 32'h000F4240, 0, 32, 1);
        repeat (32) @(negedge clock);
        chk("done_rdy_before_issue", {31'd0, data_resultRDY}, 32'd1);
        start_op(1, 0, 32'hFFFFFFFF, 32'h12345678, 5'd16, 32'hEDCBA988, 0, 32, 1);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_rdy_single", {31'd0, data_resultRDY}, 32'd0);
        wait_drain(100);

        // reset mid-MUL aborts with no ready pulse
        start_op(1, 0, 32'd5, 32'd6, 5'd17, 32'd30, 0, 32, 1);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        q.delete();
        #1;
        chk("abort_result", data_result, 32'd0);
        chk("abort_flags", {29'd0, data_exception, data_resultRDY, busy},
            32'd0);
        chk("abort_tag", {27'd0, out_tag}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        start_op(1, 0, 32'd3, 32'd4, 5'd9, 32'd12, 0, 32, 1);
        wait_drain(100);
        repeat (5) @(negedge clock);
        chk("final_idle_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
